// File: rtl/player_move_sequencer_if.sv
// Button, frame-tick and move-command bundle between the board, the sequencer and the position datapath.
interface player_move_if;
  logic       left_button;
  logic       right_button;
  logic       frame_tick;
  logic       move_ready;
  logic       move_valid;
  logic       move_dir;
  logic [9:0] move_step;
  logic       held;

  modport master (
    input  left_button, right_button, frame_tick, move_ready,
    output move_valid, move_dir, move_step, held
  );

  modport slave (
    output left_button, right_button, frame_tick, move_ready,
    input  move_valid, move_dir, move_step, held
  );
endinterface

// File: rtl/player_move_sequencer.sv
// Debounced left/right buttons -> frame-paced move commands; first move 2+DEBOUNCE+2 cycles after a press edge.
// One outstanding command; requests made while a command waits on move_ready are dropped.
module player_move_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_FRAMES     = 15,
  parameter int REPEAT_FRAMES   = 4,
  parameter int STEP            = 4
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  player_move_if.master  pm
);
  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int FMAX = (HOLD_FRAMES > REPEAT_FRAMES) ? HOLD_FRAMES : REPEAT_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);

  typedef enum logic [1:0] {IDLE, FIRST, HOLD, REPEAT} state_t;

  // bit 0 = left, bit 1 = right; 1 = released
  logic [1:0]         raw;
  logic [1:0]         sync_a;
  logic [1:0]         sync_b;
  logic [1:0]         level;
  logic [1:0][DW-1:0] db_cnt;

  state_t        state, state_nxt;
  logic          owner, owner_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt, fcnt_inc;
  logic          req;
  logic          valid_q;
  logic          dir_q;

  assign raw = {pm.right_button, pm.left_button};

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_a <= 2'b11;
      sync_b <= 2'b11;
      level  <= 2'b11;
      db_cnt <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          level[i]  <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign fcnt_inc = (fcnt == FW'(FMAX)) ? fcnt : fcnt + 1'b1;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    fcnt_nxt  = fcnt;
    req       = 1'b0;
    if (state == IDLE) begin
      // left wins a simultaneous press; a still-held non-owner takes over here
      if (!level[0]) begin
        owner_nxt = 1'b0;
        state_nxt = FIRST;
      end else if (!level[1]) begin
        owner_nxt = 1'b1;
        state_nxt = FIRST;
      end
    end else if (level[owner]) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        FIRST: begin
          req       = 1'b1;
          fcnt_nxt  = '0;
          state_nxt = HOLD;
        end
        HOLD: if (pm.frame_tick) begin
          if (fcnt == FW'(HOLD_FRAMES - 1)) begin
            req       = 1'b1;
            fcnt_nxt  = '0;
            state_nxt = REPEAT;
          end else begin
            fcnt_nxt = fcnt_inc;
          end
        end
        REPEAT: if (pm.frame_tick) begin
          if (fcnt == FW'(REPEAT_FRAMES - 1)) begin
            req      = 1'b1;
            fcnt_nxt = '0;
          end else begin
            fcnt_nxt = fcnt_inc;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      valid_q <= 1'b0;
      dir_q   <= 1'b0;
    end else if (req && (!valid_q || pm.move_ready)) begin
      valid_q <= 1'b1;
      dir_q   <= owner;
    end else if (pm.move_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign pm.move_valid = valid_q;
  assign pm.move_dir   = dir_q;
  assign pm.move_step  = 10'(STEP);
  assign pm.held       = (state != IDLE);
endmodule

// File: tb/tb_player_move_sequencer.sv
// Randomized and directed stimulus against a tick-counting reference model, with a queue-based move scoreboard.
module tb_player_move_sequencer;
  localparam int D    = 4;
  localparam int H    = 3;
  localparam int R    = 2;
  localparam int STEP = 4;
  localparam int FP   = 6;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  player_move_if pm();

  player_move_sequencer #(
    .DEBOUNCE_CYCLES(D), .HOLD_FRAMES(H), .REPEAT_FRAMES(R), .STEP(STEP)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .pm(pm)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int cyc;
    bit dir;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fcount = 0;

  // reference model: owner = -1 when nothing is held; ticks counted from the first step
  bit m_d0[2], m_d1[2], m_acc[2];
  int m_run[2];
  int m_owner = -1;
  bit m_first = 0;
  int m_ticks = 0;
  bit m_v = 0;
  bit exp_held = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic model_step(bit l, bit r, bit tk, bit rdy, bit rs);
    bit   req;
    bit   rdir;
    bit   btn[2];
    exp_t e;
    req    = 1'b0;
    btn[0] = l;
    btn[1] = r;
    cyc++;
    if (rs) begin
      if (m_v) void'(sb.pop_back());
      for (int i = 0; i < 2; i++) begin
        m_d0[i] = 1'b1; m_d1[i] = 1'b1; m_acc[i] = 1'b1; m_run[i] = 0;
      end
      m_owner = -1; m_first = 0; m_ticks = 0; m_v = 0; exp_held = 0;
      return;
    end
    if (m_owner < 0) begin
      if (!m_acc[0]) begin
        m_owner = 0; m_first = 1;
      end else if (!m_acc[1]) begin
        m_owner = 1; m_first = 1;
      end
    end else if (m_acc[m_owner]) begin
      m_owner = -1;
    end else if (m_first) begin
      req = 1'b1; m_first = 0; m_ticks = 0;
    end else if (tk) begin
      m_ticks++;
      if (m_ticks == H || (m_ticks > H && (m_ticks - H) % R == 0)) req = 1'b1;
    end
    rdir = (m_owner == 1);
    if (req && (!m_v || rdy)) begin
      m_v   = 1'b1;
      e.cyc = cyc;
      e.dir = rdir;
      sb.push_back(e);
    end else if (m_v && rdy) begin
      m_v = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_d1[i] != m_acc[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_acc[i] = m_d1[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_d1[i] = m_d0[i];
      m_d0[i] = btn[i];
    end
    exp_held = (m_owner >= 0);
  endtask

  task automatic drive(bit l, bit r, bit rdy, bit rs);
    bit tk;
    if (rs) rdy = 1'b0;
    tk = (fcount == 0);
    pm.left_button  = l;
    pm.right_button = r;
    pm.move_ready   = rdy;
    pm.frame_tick   = tk;
    reset           = rs;
    @(posedge CLOCK_50);
    model_step(l, r, tk, rdy, rs);
    fcount = (fcount + 1) % FP;
    #1;
  endtask

  // monitor: pops the scoreboard on each DUT acceptance, checks protocol and held every cycle
  bit p_v = 0, p_rdy = 0, p_dir = 0, p_rst = 1, p_acc = 0;
  int start = 0;

  always @(negedge CLOCK_50) begin
    bit   acc;
    exp_t e;
    if (cyc >= 1) begin
      if (p_rst) begin
        check("reset_valid", 32'(pm.move_valid), 0);
        check("reset_step", 32'(pm.move_step), STEP);
      end
      check("held", 32'(pm.held), 32'(exp_held));
      if (!p_rst && p_v && !p_rdy) begin
        check("valid_kept", 32'(pm.move_valid), 1);
        if (pm.move_valid === 1'b1) check("dir_stable", 32'(pm.move_dir), 32'(p_dir));
      end
      if (pm.move_valid === 1'b1 && (!p_v || p_acc)) start = cyc;
      acc = (pm.move_valid === 1'b1) && (pm.move_ready === 1'b1);
      if (acc) begin
        if (sb.size() == 0) begin
          check("unexpected_move", 32'(pm.move_dir) + 32'd100, 32'd0);
        end else begin
          e = sb.pop_front();
          check("move_dir", 32'(pm.move_dir), 32'(e.dir));
          check("move_start_cycle", 32'(start), 32'(e.cyc));
          check("move_step", 32'(pm.move_step), STEP);
        end
      end
      p_v   = pm.move_valid;
      p_rdy = pm.move_ready;
      p_dir = pm.move_dir;
      p_rst = reset;
      p_acc = acc;
    end
  end

  initial begin
    bit lv, rv, rdy, rs;
    int lt, rt, st, n;
    pm.left_button  = 1'b1;
    pm.right_button = 1'b1;
    pm.move_ready   = 1'b1;
    pm.frame_tick   = 1'b0;
    #1;
    repeat (3) drive(1, 1, 1, 1);

    // bounce shorter than the debounce window
    repeat (2) drive(0, 1, 1, 0);
    repeat (20) drive(1, 1, 1, 0);

    // left held for six frames then released
    repeat (6 * FP + 10) drive(0, 1, 1, 0);
    repeat (30) drive(1, 1, 1, 0);

    // simultaneous press, then left released with right still down
    repeat (40) drive(0, 0, 1, 0);
    repeat (30) drive(1, 0, 1, 0);
    repeat (20) drive(1, 1, 1, 0);

    // right held with the datapath stalled, then ready raised
    repeat (5 * FP + 10) drive(1, 0, 0, 0);
    repeat (4) drive(1, 0, 1, 0);
    repeat (20) drive(1, 1, 1, 0);

    // reset while a repeat command is pending
    repeat (34) drive(0, 1, 1, 0);
    n = 0;
    while (!(m_v && m_ticks >= H) && n < 40) begin
      drive(0, 1, 0, 0);
      n++;
    end
    check("repeat_pending_reached", 32'(n < 40), 1);
    drive(0, 1, 0, 1);
    repeat (30) drive(0, 1, 1, 0);
    repeat (20) drive(1, 1, 1, 0);

    // random buttons, ready stalls and occasional resets
    lv = 1; rv = 1; lt = 0; rt = 5; st = 0;
    for (int c = 0; c < 2500; c++) begin
      if (lt == 0) begin
        lv = !lv;
        lt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(10, 90);
      end else lt--;
      if (rt == 0) begin
        rv = !rv;
        rt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(10, 90);
      end else rt--;
      if (st > 0) begin
        st--;
        rdy = 0;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 60) == 0) st = $urandom_range(5, 25);
      end
      rs = ($urandom_range(0, 499) == 0);
      drive(lv, rv, rdy, rs);
    end

    repeat (40) drive(1, 1, 1, 0);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
